// File: rtl/thread_dispatcher.sv
// thread_dispatcher: issues LOAD, then fetches, decodes and issues instructions to one
// func_unit lane until RETURN (or budget exhaustion), then reports completion.
module thread_dispatcher #(
  parameter int PC_W      = 8,
  parameter int MAX_INSTR = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            launch_valid,
  output logic            launch_ready,
  input  logic [PC_W-1:0] launch_pc,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic [2:0]      fu_type,
  output logic [4:0]      fu_regnum_1,
  output logic [4:0]      fu_regnum_2,
  output logic [4:0]      fu_dest_reg,
  output logic [5:0]      fu_shammt,
  output logic            fu_issue,
  input  logic            fu_thread_complete,
  output logic            busy,
  output logic            done,
  output logic            err
);
  localparam int CW = $clog2(MAX_INSTR + 1);
  localparam logic [2:0] T_LOAD = 3'b110;
  localparam logic [2:0] T_RET  = 3'b111;
  typedef enum logic [2:0] {IDLE, LOAD, FETCH, WAIT, ISSUE, FORCE, DRAIN, DONE} state_t;
  state_t          state_q;
  logic [PC_W-1:0] pc_q;
  logic [CW-1:0]   count_q;
  logic            imem_req_q;
  logic [PC_W-1:0] imem_addr_q;
  logic [2:0]      fu_type_q;
  logic [4:0]      fu_rs1_q;
  logic [4:0]      fu_rs2_q;
  logic [4:0]      fu_dest_q;
  logic [5:0]      fu_sh_q;
  logic            fu_issue_q;
  logic            done_q;
  logic            err_q;
  logic            unused_low;
  assign launch_ready = state_q == IDLE;
  assign busy         = state_q != IDLE;
  assign imem_req     = imem_req_q;
  assign imem_addr    = imem_addr_q;
  assign fu_type      = fu_type_q;
  assign fu_regnum_1  = fu_rs1_q;
  assign fu_regnum_2  = fu_rs2_q;
  assign fu_dest_reg  = fu_dest_q;
  assign fu_shammt    = fu_sh_q;
  assign fu_issue     = fu_issue_q;
  assign done         = done_q;
  assign err          = err_q;
  assign unused_low   = ^imem_rdata[7:0];
  // Outputs are registered: each branch loads what the next state must present.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      pc_q        <= '0;
      count_q     <= '0;
      imem_req_q  <= 1'b0;
      imem_addr_q <= '0;
      fu_type_q   <= T_RET;
      fu_rs1_q    <= '0;
      fu_rs2_q    <= '0;
      fu_dest_q   <= '0;
      fu_sh_q     <= '0;
      fu_issue_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      imem_req_q <= 1'b0;
      fu_type_q  <= T_RET;
      fu_rs1_q   <= '0;
      fu_rs2_q   <= '0;
      fu_dest_q  <= '0;
      fu_sh_q    <= '0;
      fu_issue_q <= 1'b0;
      done_q     <= 1'b0;
      case (state_q)
        IDLE: if (launch_valid) begin
          state_q    <= LOAD;
          pc_q       <= launch_pc;
          count_q    <= '0;
          err_q      <= 1'b0;
          fu_type_q  <= T_LOAD;
          fu_issue_q <= 1'b1;
        end
        LOAD: begin
          state_q     <= FETCH;
          imem_req_q  <= 1'b1;
          imem_addr_q <= pc_q;
        end
        FETCH: begin
          state_q <= WAIT;
          count_q <= count_q + CW'(1);
        end
        WAIT: if (imem_rvalid) begin
          state_q    <= ISSUE;
          fu_type_q  <= imem_rdata[31:29];
          fu_dest_q  <= imem_rdata[28:24];
          fu_rs1_q   <= imem_rdata[23:19];
          fu_rs2_q   <= imem_rdata[18:14];
          fu_sh_q    <= imem_rdata[13:8];
          fu_issue_q <= 1'b1;
        end
        ISSUE: begin
          pc_q <= pc_q + PC_W'(1);
          if (fu_type_q == T_RET) state_q <= DRAIN;
          else if (count_q == CW'(MAX_INSTR)) begin
            state_q    <= FORCE;
            fu_issue_q <= 1'b1;
          end else begin
            state_q     <= FETCH;
            imem_req_q  <= 1'b1;
            imem_addr_q <= pc_q + PC_W'(1);
          end
        end
        FORCE: begin
          state_q <= DRAIN;
          err_q   <= 1'b1;
        end
        DRAIN: if (fu_thread_complete) begin
          state_q <= DONE;
          done_q  <= 1'b1;
        end
        DONE: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_thread_dispatcher.sv
// tb_thread_dispatcher: directed scenarios against thread_dispatcher with a small
// program memory and func_unit model.
module tb_thread_dispatcher;
  localparam logic [31:0] ADD_W  = {3'b000, 5'd3, 5'd1, 5'd2, 6'd0, 8'hA5};
  localparam logic [31:0] SUB_W  = {3'b001, 5'd4, 5'd3, 5'd1, 6'd5, 8'h3C};
  localparam logic [31:0] RET_W  = {3'b111, 29'd0};
  localparam logic [23:0] ADD_E  = {3'b000, 5'd3, 5'd1, 5'd2, 6'd0};
  localparam logic [23:0] SUB_E  = {3'b001, 5'd4, 5'd3, 5'd1, 6'd5};
  localparam logic [23:0] RET_E  = {3'b111, 21'd0};
  localparam logic [23:0] LOAD_E = {3'b110, 21'd0};
  logic clk = 0, rst = 0, launch_valid = 0, imem_rvalid = 0, fu_thread_complete = 0;
  logic [7:0] launch_pc = 0;
  logic [31:0] imem_rdata = 0;
  logic launch_ready, imem_req, fu_issue, busy, done, err;
  logic [7:0] imem_addr;
  logic [2:0] fu_type;
  logic [4:0] fu_regnum_1, fu_regnum_2, fu_dest_reg;
  logic [5:0] fu_shammt;
  int n_cmp = 0, n_bad = 0;
  int cyc = 0, mem_lat = 1, req_cd = 0, done_cnt = 0, done_cyc = 0, bub_bad = 0, rv_idle = 0;
  int acc_cyc = 0, ib = 0, fb = 0, db = 0, bb = 0, rb = 0;
  logic ret_flag = 0;
  logic [7:0] req_addr = 0;
  logic [31:0] prog [0:255];
  logic [7:0] fetch_log [$];
  logic [23:0] iss_log [$];
  int iss_cyc [$], req_cyc [$];

  thread_dispatcher #(.PC_W(8), .MAX_INSTR(4)) dut (
    .clk(clk), .rst(rst), .launch_valid(launch_valid), .launch_ready(launch_ready),
    .launch_pc(launch_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .fu_type(fu_type),
    .fu_regnum_1(fu_regnum_1), .fu_regnum_2(fu_regnum_2), .fu_dest_reg(fu_dest_reg),
    .fu_shammt(fu_shammt), .fu_issue(fu_issue), .fu_thread_complete(fu_thread_complete),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Monitor at negedge; memory and func_unit responses driven just after posedge.
  always begin
    @(negedge clk);
    if (imem_req) begin
      req_cd = mem_lat;
      req_addr = imem_addr;
      fetch_log.push_back(imem_addr);
      req_cyc.push_back(cyc);
    end
    if (fu_issue) begin
      iss_log.push_back({fu_type, fu_dest_reg, fu_regnum_1, fu_regnum_2, fu_shammt});
      iss_cyc.push_back(cyc);
      if (fu_type == 3'b111) ret_flag = 1;
    end else if ({fu_type, fu_dest_reg, fu_regnum_1, fu_regnum_2, fu_shammt} !== RET_E) bub_bad++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (imem_rvalid && !busy) rv_idle++;
    @(posedge clk);
    #1;
    cyc++;
    imem_rvalid = 0;
    fu_thread_complete = ret_flag;
    ret_flag = 0;
    if (req_cd > 0) begin
      req_cd--;
      if (req_cd == 0) begin
        imem_rvalid = 1;
        imem_rdata = prog[req_addr];
      end
    end
  end

  task automatic mark();
    ib = iss_log.size(); fb = fetch_log.size(); db = done_cnt; bb = bub_bad; rb = rv_idle;
  endtask

  task automatic launch(input logic [7:0] pc);
    @(negedge clk);
    launch_valid = 1;
    launch_pc = pc;
    @(posedge clk);
    #1 launch_valid = 0;
    @(negedge clk);
    acc_cyc = cyc;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done === 1'b1) return;
    end
    n_cmp++; n_bad++;
    $display("FAIL done_timeout got no done want done within 300 cycles");
  endtask

  task automatic test_reset();
    #3 rst = 1;
    #1;
    n_cmp++; if (launch_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready got %b want 1", launch_ready); end
    n_cmp++; if (fu_type !== 3'b111) begin n_bad++; $display("FAIL rst_type got %b want 111", fu_type); end
    n_cmp++; if (fu_issue !== 1'b0) begin n_bad++; $display("FAIL rst_issue got %b want 0", fu_issue); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rst_done got %b want 0", done); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL rst_err got %b want 0", err); end
    n_cmp++; if (imem_req !== 1'b0 || imem_addr !== 8'h00) begin n_bad++; $display("FAIL rst_imem got %b/%h want 0/00", imem_req, imem_addr); end
    @(negedge clk) rst = 0;
  endtask

  task automatic test_basic();
    logic [23:0] e [0:3] = '{LOAD_E, ADD_E, SUB_E, RET_E};
    mark(); mem_lat = 1;
    launch(8'h10);
    wait_done();
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL basic_after got busy=%b done=%b want 0/0", busy, done); end
    n_cmp++; if (done_cnt - db != 1) begin n_bad++; $display("FAIL basic_done_cnt got %0d want 1", done_cnt - db); end
    n_cmp++; if (iss_log.size() - ib != 4) begin n_bad++; $display("FAIL basic_n_iss got %0d want 4", iss_log.size() - ib); end
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (iss_log[ib+k] !== e[k]) begin n_bad++; $display("FAIL basic_iss%0d got %h want %h", k, iss_log[ib+k], e[k]); end
    end
    n_cmp++; if (fetch_log.size() - fb != 3) begin n_bad++; $display("FAIL basic_n_fetch got %0d want 3", fetch_log.size() - fb); end
    for (int k = 0; k < 3; k++) begin
      n_cmp++; if (fetch_log[fb+k] !== 8'h10 + 8'(k)) begin n_bad++; $display("FAIL basic_addr%0d got %h want %h", k, fetch_log[fb+k], 8'h10 + 8'(k)); end
    end
    n_cmp++; if (iss_cyc[ib] != acc_cyc) begin n_bad++; $display("FAIL basic_load_cyc got %0d want %0d", iss_cyc[ib], acc_cyc); end
    n_cmp++; if (req_cyc[fb] != acc_cyc + 1) begin n_bad++; $display("FAIL basic_req_cyc got %0d want %0d", req_cyc[fb], acc_cyc + 1); end
    n_cmp++; if (iss_cyc[ib+3] - iss_cyc[ib] != 9) begin n_bad++; $display("FAIL basic_span got %0d want 9", iss_cyc[ib+3] - iss_cyc[ib]); end
    n_cmp++; if (done_cyc - iss_cyc[ib+3] != 2) begin n_bad++; $display("FAIL basic_done_lat got %0d want 2", done_cyc - iss_cyc[ib+3]); end
  endtask

  task automatic test_slow_mem();
    logic [23:0] e [0:3] = '{LOAD_E, ADD_E, SUB_E, RET_E};
    mark(); mem_lat = 3;
    launch(8'h10);
    wait_done();
    @(negedge clk);
    n_cmp++; if (iss_log.size() - ib != 4) begin n_bad++; $display("FAIL slow_n_iss got %0d want 4", iss_log.size() - ib); end
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (iss_log[ib+k] !== e[k]) begin n_bad++; $display("FAIL slow_iss%0d got %h want %h", k, iss_log[ib+k], e[k]); end
    end
    n_cmp++; if (bub_bad - bb != 0) begin n_bad++; $display("FAIL slow_bubble got %0d bad cycles want 0", bub_bad - bb); end
    n_cmp++; if (iss_cyc[ib+3] - iss_cyc[ib] != 15) begin n_bad++; $display("FAIL slow_span got %0d want 15", iss_cyc[ib+3] - iss_cyc[ib]); end
    n_cmp++; if (done_cnt - db != 1) begin n_bad++; $display("FAIL slow_done_cnt got %0d want 1", done_cnt - db); end
  endtask

  task automatic test_budget();
    mark(); mem_lat = 1;
    launch(8'h40);
    wait_done();
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL budget_err_done got %b want 1", err); end
    @(negedge clk);
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL budget_err_sticky got %b want 1", err); end
    n_cmp++; if (fetch_log.size() - fb != 4) begin n_bad++; $display("FAIL budget_n_fetch got %0d want 4", fetch_log.size() - fb); end
    n_cmp++; if (fetch_log[fb+3] !== 8'h43) begin n_bad++; $display("FAIL budget_last_addr got %h want 43", fetch_log[fb+3]); end
    n_cmp++; if (iss_log.size() - ib != 6) begin n_bad++; $display("FAIL budget_n_iss got %0d want 6", iss_log.size() - ib); end
    n_cmp++; if (iss_log[ib+4] !== ADD_E) begin n_bad++; $display("FAIL budget_iss4 got %h want %h", iss_log[ib+4], ADD_E); end
    n_cmp++; if (iss_log[ib+5] !== RET_E) begin n_bad++; $display("FAIL budget_forced got %h want %h", iss_log[ib+5], RET_E); end
    launch(8'h10);
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL budget_err_clear got %b want 0", err); end
    wait_done();
    @(negedge clk);
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL budget_err_normal got %b want 0", err); end
  endtask

  task automatic test_held_launch();
    int rdy_bad = 0, loads = 0;
    bit seen = 0;
    mark(); mem_lat = 1;
    @(negedge clk);
    launch_valid = 1;
    launch_pc = 8'h10;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (busy && launch_ready) rdy_bad++;
      if (done === 1'b1) begin
        seen = 1;
        launch_valid = 0;
      end
    end
    launch_valid = 0;
    @(negedge clk);
    for (int k = ib; k < iss_log.size(); k++) if (iss_log[k] === LOAD_E) loads++;
    n_cmp++; if (!seen) begin n_bad++; $display("FAIL held_timeout got no done want done"); end
    n_cmp++; if (loads != 1) begin n_bad++; $display("FAIL held_loads got %0d want 1", loads); end
    n_cmp++; if (rdy_bad != 0) begin n_bad++; $display("FAIL held_ready_busy got %0d want 0", rdy_bad); end
    n_cmp++; if (busy !== 1'b0 || launch_ready !== 1'b1) begin n_bad++; $display("FAIL held_idle got busy=%b ready=%b want 0/1", busy, launch_ready); end
  endtask

  task automatic test_reset_wait();
    mem_lat = 3;
    launch(8'h10);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1;
    #1;
    n_cmp++; if (launch_ready !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL rstw_state got ready=%b busy=%b want 1/0", launch_ready, busy); end
    n_cmp++; if (fu_type !== 3'b111 || fu_issue !== 1'b0) begin n_bad++; $display("FAIL rstw_bubble got %b/%b want 111/0", fu_type, fu_issue); end
    mark();
    @(negedge clk) rst = 0;
    repeat (8) @(negedge clk);
    n_cmp++; if (rv_idle - rb != 1) begin n_bad++; $display("FAIL rstw_stale got %0d want 1", rv_idle - rb); end
    n_cmp++; if (iss_log.size() - ib != 0) begin n_bad++; $display("FAIL rstw_issue got %0d want 0", iss_log.size() - ib); end
    n_cmp++; if (fetch_log.size() - fb != 0) begin n_bad++; $display("FAIL rstw_fetch got %0d want 0", fetch_log.size() - fb); end
    n_cmp++; if (busy !== 1'b0 || launch_ready !== 1'b1) begin n_bad++; $display("FAIL rstw_idle got busy=%b ready=%b want 0/1", busy, launch_ready); end
  endtask

  task automatic test_wrap();
    mark(); mem_lat = 1;
    launch(8'hFF);
    wait_done();
    @(negedge clk);
    n_cmp++; if (fetch_log.size() - fb != 2) begin n_bad++; $display("FAIL wrap_n_fetch got %0d want 2", fetch_log.size() - fb); end
    n_cmp++; if (fetch_log[fb] !== 8'hFF) begin n_bad++; $display("FAIL wrap_addr0 got %h want ff", fetch_log[fb]); end
    n_cmp++; if (fetch_log[fb+1] !== 8'h00) begin n_bad++; $display("FAIL wrap_addr1 got %h want 00", fetch_log[fb+1]); end
    n_cmp++; if (iss_log.size() - ib != 3) begin n_bad++; $display("FAIL wrap_n_iss got %0d want 3", iss_log.size() - ib); end
    n_cmp++; if (iss_log[ib+2] !== RET_E) begin n_bad++; $display("FAIL wrap_ret got %h want %h", iss_log[ib+2], RET_E); end
    n_cmp++; if (done_cnt - db != 1) begin n_bad++; $display("FAIL wrap_done_cnt got %0d want 1", done_cnt - db); end
  endtask

  initial begin
    for (int a = 0; a < 256; a++) prog[a] = ADD_W;
    prog[8'h10] = ADD_W; prog[8'h11] = SUB_W; prog[8'h12] = RET_W;
    prog[8'hFF] = ADD_W; prog[8'h00] = RET_W;
    test_reset();
    test_basic();
    test_slow_mem();
    test_budget();
    test_held_launch();
    test_reset_wait();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
